// File: rtl/seq_restoring_divider_pkg.sv
// Shared state encoding and sizing helper for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int CNT_W(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus between a controller and the divider.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_addsub.sv
// Ripple-carry adder/subtractor: i_en=1 computes i_a - i_b with o_cout=1 meaning no borrow.
module addsub_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_en,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0]   w_carry;
  logic [N-1:0] w_bx;

  assign w_bx       = i_b ^ {N{i_en}};
  assign w_carry[0] = i_en;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign o_sum[i]       = i_a[i] ^ w_bx[i] ^ w_carry[i];
    assign w_carry[i + 1] = (i_a[i] & w_bx[i]) | (w_carry[i] & (i_a[i] ^ w_bx[i]));
  end

  assign o_cout = w_carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock, start/done handshake.
// The partial remainder is held in WIDTH bits because it always stays below the divisor.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = CNT_W(WIDTH);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] r_partRem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] w_nextRem;
  logic [WIDTH-1:0] w_nextQuo;
  logic [CW-1:0]    r_count;
  logic             r_divByZero;
  logic             w_carry;
  logic             w_noBorrow;
  logic             w_lastStep;

  assign w_shifted = {r_partRem, r_quo[WIDTH-1]};

  addsub_nbit #(
    .N(WIDTH + 1)
  ) u_addsub (
    .i_a   (w_shifted),
    .i_b   ({1'b0, r_divisor}),
    .i_en  (1'b1),
    .o_sum (w_trial),
    .o_cout(w_carry)
  );

  // A set top bit would mean the trial spilled past the remainder width, so it counts as a borrow.
  assign w_noBorrow = w_carry & ~w_trial[WIDTH];
  assign w_nextRem  = w_noBorrow ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign w_nextQuo  = {r_quo[WIDTH-2:0], w_noBorrow};
  assign w_lastStep = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = IDLE;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    case (r_state)
      IDLE: begin
        w_nextState = IDLE;
        if (bus.start) w_nextState = (bus.divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        bus.busy    = 1'b1;
        w_nextState = w_lastStep ? DONE : CALC;
      end
      DONE: begin
        bus.done    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Result registers only change when DONE is entered, so they hold across the next CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_partRem   <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divByZero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_divisor <= bus.divisor;
            r_quo     <= bus.dividend;
            r_partRem <= '0;
            r_count   <= '0;
            if (bus.divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= bus.dividend;
              r_divByZero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_partRem <= w_nextRem;
          r_quo     <= w_nextQuo;
          r_count   <= r_count + CW'(1);
          if (w_lastStep) begin
            r_quotient  <= w_nextQuo;
            r_remainder <= w_nextRem;
            r_divByZero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_divByZero;

endmodule
